inst_buffer: RTL and testbench
==============================

# inst_buffer

- Decoupling FIFO between the instruction cache and the decode stage.
- Accepts up to two fetched instructions per cycle, each paired with its PC, and presents up to two in program order to decode.
- Drives `ibuffer_full` back to the PC stage to throttle fetch requests.
- Discards all contents on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, ≥ 8.
- `FULL_MARGIN`, 4: free entries required for fetch to continue; covers one in-flight two-instruction response.

Ports (clock and reset first):
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: `Flush`-level pipeline flush from exception or branch-mispredict resolution.
- `in_valid` input 2: per-slot valid of the icache response; bit0 = slot0, bit1 = slot1.
- `in_inst0`, `in_inst1` input 32 each: instruction words.
- `in_pc0`, `in_pc1` input 32 each: instruction addresses.
- `id_accept` input 2: decode takes head (bit0), and head+1 (bit1, honoured only with bit0).
- `out_valid` output 2: bit0 when ≥ 1 entry stored, bit1 when ≥ 2.
- `out_inst0`, `out_inst1` output 32 each: head and head+1 instructions.
- `out_pc0`, `out_pc1` output 32 each: head and head+1 PCs.
- `ibuffer_full` output 1: free entries < `FULL_MARGIN`.
- `overflow_err` output 1: sticky; set when a write was dropped for lack of space.

## Operation
State:
- Storage array of `DEPTH` entries × {inst, pc}.
- `head` and `tail` pointers, log2(`DEPTH`) bits each, wrapping naturally.
- `count`, log2(`DEPTH`)+1 bits.

Write:
- Valid slots are compacted in order: slot0 first, then slot1.
- `in_valid` = 2'b10 writes slot1 alone into a single entry.
- `wr_num` = popcount(`in_valid`), clipped to free space.
- Any clipped instruction is dropped and sets `overflow_err`.

Read:
- `rd_num` = `id_accept[0]` + (`id_accept[0]` & `id_accept[1]`), clipped to `count`.
- Accept bits presented without matching `out_valid` are ignored.

Update:
- `head += rd_num`, `tail += wr_num`, `count += wr_num - rd_num`.
- Simultaneous read and write in one cycle is legal, including when `count` = `DEPTH`: the read frees space first, and the freed slots are usable by the write in the same cycle.

Flush:
- `flush` has priority over reads and writes.
- `head`, `tail` and `count` are cleared.
- Same-cycle writes and reads are discarded.
- `overflow_err` is unaffected.

Outputs:
- `out_*` are read combinationally from storage at `head` and `head+1`, modulo `DEPTH`.
- When not valid, they hold don't-care data.
- `ibuffer_full` = (`DEPTH` - `count`) < `FULL_MARGIN`.
- `ibuffer_full` is a function of registered state only; no input-to-output path, so the PC stage's combinational `npc` loop cannot close.

Reset:
- `count`, `head`, `tail` = 0.
- `out_valid` = 0, `ibuffer_full` = 0, `overflow_err` = 0.
- Reset mid-operation abandons all entries immediately (asynchronous).

## Timing
- Write-to-output latency: 1 cycle. Data written at edge N is visible on `out_*` after edge N; no same-cycle bypass.
- Read takes effect at the accepting edge; the next entries appear after that edge.
- `ibuffer_full` reflects post-edge `count`, so it asserts one cycle after the write that crosses the threshold.
- Flush asserted at edge N: `out_valid` = 0 and `ibuffer_full` = 0 after edge N.
- Steady state sustains 2 in + 2 out per cycle indefinitely with no bubbles.

## Structure
Shared defines (`defines.v`):
- `InstAddrBus`, `InstBus`, `Flush`, `RstEnable`.
- New constants `IbufDepth` = 16 and `IbufFullMargin` = 4.

Sub-modules:
- None required; storage is a flop array inside the block.
- A `popcount2` helper is inlined, not a separate module.

## Test plan
- Reset release, then 4 cycles of `in_valid` = 11 with PCs bfc00000..bfc0001c and `id_accept` = 00 → `count` = 8; `out_pc0` = bfc00000, `out_pc1` = bfc00004; `out_valid` = 11; `ibuffer_full` = 0.
- Continue writing 11 with no accepts → `ibuffer_full` rises the cycle after `count` reaches 14; a further 11 write at `count` 16 drops both instructions and sets `overflow_err` = 1.
- `count` = 16, same cycle `in_valid` = 11 and `id_accept` = 11 → `count` stays 16; `head` advances by 2; new entries sit at the wrapped `tail`; `overflow_err` unchanged.
- `count` = 5, `flush` = 1 together with `in_valid` = 11 and `id_accept` = 01 → next cycle `count` = 0, `out_valid` = 00, `ibuffer_full` = 0; a subsequent write of PC bfc00100 appears at `out_pc0`.
- `in_valid` = 10 with `in_pc1` = bfc00204 into an empty buffer → `out_valid` = 01, `out_pc0` = bfc00204; then `id_accept` = 10 → ignored, `count` stays 1.
- Assert `rst` low mid-stream with `count` = 9 → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared constants, types and helpers for the instruction buffer between
// the instruction cache and the decode stage.
package inst_buffer_pkg;

  // Bus widths (InstBus / InstAddrBus)
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // Buffer geometry defaults (IbufDepth / IbufFullMargin)
  localparam int IBUF_DEPTH       = 16;
  localparam int IBUF_FULL_MARGIN = 4;

  // Active levels of the pipeline control signals (Flush / RstEnable)
  localparam logic FLUSH_ACTIVE = 1'b1;
  localparam logic RST_ENABLE   = 1'b0;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] inst_addr_t;

  // One buffered instruction together with its fetch address
  typedef struct packed {
    inst_t      inst;
    inst_addr_t pc;
  } ibuf_entry_t;

  // Number of set bits in a two-slot valid vector
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer: two-wide in, two-wide out circular FIFO that
// decouples icache responses from decode. Throttles fetch through
// ibuffer_full (registered state only) and drops everything on a flush.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH       = IBUF_DEPTH,
  parameter int FULL_MARGIN = IBUF_FULL_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        in_valid,
  input  logic [INST_W-1:0] in_inst0,
  input  logic [INST_W-1:0] in_inst1,
  input  logic [ADDR_W-1:0] in_pc0,
  input  logic [ADDR_W-1:0] in_pc1,
  input  logic [1:0]        id_accept,
  output logic [1:0]        out_valid,
  output logic [INST_W-1:0] out_inst0,
  output logic [INST_W-1:0] out_inst1,
  output logic [ADDR_W-1:0] out_pc0,
  output logic [ADDR_W-1:0] out_pc1,
  output logic              ibuffer_full,
  output logic              overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

  // Handshake: a write happens for every set in_valid slot that fits
  // (no ready back to the cache; fetch is throttled by ibuffer_full and
  // anything that does not fit is dropped and flagged). Decode takes the
  // head when id_accept[0] is set and out_valid[0] is high, and head+1
  // additionally when id_accept[1] is also set and out_valid[1] is high.

  ibuf_entry_t     mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;
  logic [CW-1:0]   count;
  logic [CW-1:0]   space;
  logic [1:0]      rd_num;
  logic [1:0]      wr_req;
  logic [1:0]      wr_num;
  logic            drop;
  logic            flush_now;
  ibuf_entry_t     first_entry;
  ibuf_entry_t     second_entry;
  ibuf_entry_t     head_entry;
  ibuf_entry_t     next_entry;

  assign flush_now = (flush == FLUSH_ACTIVE);
  assign head_p1   = head + PW'(1);
  assign tail_p1   = tail + PW'(1);

  // Read count: accepts beyond the stored entries are ignored
  always_comb begin
    rd_num = 2'd0;
    if (id_accept[0] && (count != '0)) begin
      if (id_accept[1] && (count >= CW'(2))) begin
        rd_num = 2'd2;
      end else begin
        rd_num = 2'd1;
      end
    end
  end

  // Write count: the same-cycle read frees its slots before the write claims space
  always_comb begin
    wr_req = popcount2(in_valid);
    space  = DEPTH_C - count + CW'(rd_num);
    wr_num = wr_req;
    if (CW'(wr_req) > space) begin
      wr_num = space[1:0];
    end
    drop = (wr_req != wr_num);
  end

  // Compact valid slots in program order: slot0 first, then slot1
  always_comb begin
    second_entry.inst = in_inst1;
    second_entry.pc   = in_pc1;
    if (in_valid[0]) begin
      first_entry.inst = in_inst0;
      first_entry.pc   = in_pc0;
    end else begin
      first_entry.inst = in_inst1;
      first_entry.pc   = in_pc1;
    end
  end

  // Pointer and occupancy update; flush wins over any same-cycle read or write
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_now) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(rd_num);
      tail  <= tail + PW'(wr_num);
      count <= count + CW'(wr_num) - CW'(rd_num);
    end
  end

  // Sticky overflow flag; only reset clears it, a flush leaves it alone
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      overflow_err <= 1'b0;
    end else if (!flush_now && drop) begin
      overflow_err <= 1'b1;
    end
  end

  // Storage write at tail (and tail+1 for a two-entry write)
  always_ff @(posedge clk) begin
    if (!flush_now) begin
      if (wr_num != 2'd0) begin
        mem[tail] <= first_entry;
      end
      if (wr_num == 2'd2) begin
        mem[tail_p1] <= second_entry;
      end
    end
  end

  // Output view of the head pair, straight from storage (no bypass)
  always_comb begin
    head_entry = mem[head];
    next_entry = mem[head_p1];
  end

  assign out_valid    = {count >= CW'(2), count != '0};
  assign out_inst0    = head_entry.inst;
  assign out_pc0      = head_entry.pc;
  assign out_inst1    = next_entry.inst;
  assign out_pc1      = next_entry.pc;
  assign ibuffer_full = (DEPTH_C - count) < MARGIN_C;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed, table-driven bench for inst_buffer. Instruction words are the
// bitwise inverse of their PC so that data and address paths are both checked.
module tb_inst_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [31:0] in_pc0;
  logic [31:0] in_pc1;
  logic [1:0]  id_accept;
  logic [1:0]  out_valid;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic        ibuffer_full;
  logic        overflow_err;

  int n_checks;
  int n_fail;

  inst_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_inst0     (in_inst0),
    .in_inst1     (in_inst1),
    .in_pc0       (in_pc0),
    .in_pc1       (in_pc1),
    .id_accept    (id_accept),
    .out_valid    (out_valid),
    .out_inst0    (out_inst0),
    .out_inst1    (out_inst1),
    .out_pc0      (out_pc0),
    .out_pc1      (out_pc1),
    .ibuffer_full (ibuffer_full),
    .overflow_err (overflow_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush;
    logic [1:0]  iv;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  acc;
    logic [1:0]  ev;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic        efull;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic [1:0] iv, logic [31:0] pc0,
                              logic [31:0] pc1, logic [1:0] acc, logic [1:0] ev,
                              logic [31:0] epc0, logic [31:0] epc1,
                              logic efull, logic eovf);
    vec_t v;
    v.flush = f;   v.iv = iv;     v.pc0 = pc0;   v.pc1 = pc1;  v.acc = acc;
    v.ev = ev;     v.epc0 = epc0; v.epc1 = epc1; v.efull = efull; v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [1:0] iv, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic [1:0] acc);
    flush     = f;
    in_valid  = iv;
    in_pc0    = pc0;
    in_pc1    = pc1;
    in_inst0  = ~pc0;
    in_inst1  = ~pc1;
    id_accept = acc;
  endtask

  // Drive at the falling edge, let one rising edge pass, sample 1ns later
  task automatic step(input logic f, input logic [1:0] iv, input logic [31:0] pc0,
                      input logic [31:0] pc1, input logic [1:0] acc);
    @(negedge clk);
    drive(f, iv, pc0, pc1, acc);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] ev, input logic [31:0] epc0,
                               input logic [31:0] epc1, input logic efull, input logic eovf);
    check({tag, ".out_valid"}, {30'd0, out_valid}, {30'd0, ev});
    check({tag, ".ibuffer_full"}, {31'd0, ibuffer_full}, {31'd0, efull});
    check({tag, ".overflow_err"}, {31'd0, overflow_err}, {31'd0, eovf});
    if (ev[0]) begin
      check({tag, ".out_pc0"}, out_pc0, epc0);
      check({tag, ".out_inst0"}, out_inst0, ~epc0);
    end
    if (ev[1]) begin
      check({tag, ".out_pc1"}, out_pc1, epc1);
      check({tag, ".out_inst1"}, out_inst1, ~epc1);
    end
  endtask

  localparam logic [31:0] B = 32'hbfc0_0000;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b00);

    //                 flush iv     pc0         pc1         acc    ev     epc0        epc1        full  ovf
    // fill to 16 with no accepts
    vecs.push_back(mk(1'b0, 2'b11, B+32'h00, B+32'h04, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h08, B+32'h0c, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h10, B+32'h14, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h18, B+32'h1c, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h20, B+32'h24, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h28, B+32'h2c, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h30, B+32'h34, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h38, B+32'h3c, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b1, 1'b0));
    // full: both dropped
    vecs.push_back(mk(1'b0, 2'b11, B+32'h40, B+32'h44, 2'b00, 2'b11, B+32'h00, B+32'h04, 1'b1, 1'b1));
    // full: read 2 and write 2 in the same cycle
    vecs.push_back(mk(1'b0, 2'b11, B+32'h48, B+32'h4c, 2'b11, 2'b11, B+32'h08, B+32'h0c, 1'b1, 1'b1));
    // drain in pairs, the last pair being the wrapped write
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h10, B+32'h14, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h18, B+32'h1c, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h20, B+32'h24, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h28, B+32'h2c, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h30, B+32'h34, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h38, B+32'h3c, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b11, B+32'h48, B+32'h4c, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b01, 2'b01, B+32'h4c, 32'd0,    1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b01, 2'b00, 32'd0,    32'd0,    1'b0, 1'b1));
    // build count 5, then flush with a simultaneous write and read
    vecs.push_back(mk(1'b0, 2'b11, B+32'h80, B+32'h84, 2'b00, 2'b11, B+32'h80, B+32'h84, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h88, B+32'h8c, 2'b00, 2'b11, B+32'h80, B+32'h84, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b01, B+32'h90, B+32'h94, 2'b00, 2'b11, B+32'h80, B+32'h84, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b11, B+32'ha0, B+32'ha4, 2'b01, 2'b00, 32'd0,    32'd0,    1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b01, B+32'h100, B+32'h104, 2'b00, 2'b01, B+32'h100, 32'd0,  1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b01, 2'b00, 32'd0,    32'd0,    1'b0, 1'b1));
    // slot1-only write, then a lone accept bit1 is ignored
    vecs.push_back(mk(1'b0, 2'b10, 32'hdeadbeef, B+32'h204, 2'b00, 2'b01, B+32'h204, 32'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b10, 2'b01, B+32'h204, 32'd0,   1'b0, 1'b1));
    // accept 11 with one entry is clipped to one
    vecs.push_back(mk(1'b0, 2'b00, 32'd0,    32'd0,    2'b11, 2'b00, 32'd0,    32'd0,    1'b0, 1'b1));
    // accepts on an empty buffer ignored while writing; then read 1 + write 2
    vecs.push_back(mk(1'b0, 2'b11, B+32'h300, B+32'h304, 2'b11, 2'b11, B+32'h300, B+32'h304, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 2'b11, B+32'h308, B+32'h30c, 2'b01, 2'b11, B+32'h304, B+32'h308, 1'b0, 1'b1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table
    foreach (vecs[i]) begin
      step(vecs[i].flush, vecs[i].iv, vecs[i].pc0, vecs[i].pc1, vecs[i].acc);
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc0, vecs[i].epc1,
                    vecs[i].efull, vecs[i].eovf);
    end

    // Grow from 3 to 9 entries, then reset asynchronously between edges
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, B+32'h310+32'(8*i), B+32'h314+32'(8*i), 2'b00);
    end
    check_outputs("pre_rst", 2'b11, B+32'h304, B+32'h308, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Partial clip: 15 entries, two offered, only slot0 fits
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 2'b11, 32'h500+32'(8*i), 32'h504+32'(8*i), 2'b00);
    end
    step(1'b0, 2'b01, 32'h538, 32'h0, 2'b00);
    check_outputs("cnt15", 2'b11, 32'h500, 32'h504, 1'b1, 1'b0);
    step(1'b0, 2'b11, 32'h53c, 32'h540, 2'b00);
    check_outputs("clip1", 2'b11, 32'h500, 32'h504, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 2'b00, 32'd0, 32'd0, 2'b11);
    end
    check_outputs("clip_tail", 2'b11, 32'h538, 32'h53c, 1'b0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 2'b11);
    check_outputs("clip_empty", 2'b00, 32'd0, 32'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
